sad_sched: RTL and testbench
============================

Name: sad_sched

Overview:
- Sequences the 5-candidate row SAD datapath (lanes h, q, f, r, i; each lane 12 bits per row) over one block of NUM_ROWS rows.
- Requests rows one at a time and accumulates each lane's per-row SAD.
- After the last row, picks the minimum-cost candidate and reports its index and SAD.
- Sits between the motion-estimation top-level control and the row SAD datapath.

Parameters:
- NUM_ROWS, 6, rows per block; legal range 1..64.
- ACC_W, 16, accumulator width per lane; must be >= 12.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  one-cycle pulse; begins a block; ignored unless idle
- row_req  out  1  high while requesting the row given by row_idx
- row_idx  out  6  index of the requested row, 0..NUM_ROWS-1
- row_valid  in  1  datapath presents sad_vector for row_idx; sampled only while row_req=1
- sad_vector  in  60  packed lane SADs: [11:0]=h, [23:12]=q, [35:24]=f, [47:36]=r, [59:48]=i
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse; result valid
- best_idx  out  3  winning lane: 0=h, 1=q, 2=f, 3=r, 4=i
- best_sad  out  ACC_W  accumulated SAD of the winning lane

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - State goes to IDLE; all accumulators clear to 0.
  - row_req=0, row_idx=0, busy=0, done=0, best_idx=0, best_sad=0.
  - Reset mid-block discards all partial work; no done is issued.
- FSM states: IDLE, RUN, CMP, DONE.
- IDLE:
  - On start=1: clear the 5 accumulators and row_idx, then go to RUN.
  - start in any other state is ignored.
- RUN:
  - row_req=1.
  - On row_valid=1, add each 12-bit lane, zero-extended, into its accumulator and increment row_idx.
  - Accepting row NUM_ROWS-1 transitions to CMP; row_idx returns to 0.
  - With row_valid=0, hold state and accumulators (stall allowed indefinitely).
- Arithmetic:
  - Accumulator adds saturate at 2^ACC_W-1; no wrap.
  - At defaults the maximum is 6*6*255=9180, so no saturation occurs.
- CMP:
  - Sequential scan, one lane per cycle, lane 0 through 4 (5 cycles).
  - The running minimum starts with lane 0.
  - A later lane replaces the running minimum only if strictly smaller, so ties go to the lowest index.
  - Then go to DONE.
- DONE:
  - done=1 for exactly one cycle.
  - best_idx/best_sad update on entry to DONE and hold until the next start.
  - Next cycle: IDLE.
- Latency: start sampled at cycle 0 with row_valid held 1 gives row_req high at cycles 1..NUM_ROWS and done at cycle NUM_ROWS+6 (cycle 12 at defaults). Each stall cycle adds 1.
- Back-to-back: start is accepted in the IDLE cycle immediately after DONE.
- best_idx/best_sad stay stable during a new block until its DONE.

Optional Feature:
- Macro: SAD_SCHED_ABORT_EN.
- When defined:
  - Adds input abort (1 bit).
  - abort=1 in RUN or CMP returns the FSM to IDLE next cycle with no done.
  - Accumulators are cleared; best_idx/best_sad keep their previous values.
  - abort has priority over row_valid in the same cycle.
  - abort in IDLE or DONE is ignored.
- When undefined: no abort port; behaviour exactly as above.

Decomposition:
- Shared package holds:
  - Lane index constants LANE_H=0, LANE_Q=1, LANE_F=2, LANE_R=3, LANE_I=4.
  - NUM_LANES=5, LANE_W=12.
  - The FSM state enum.
- One natural sub-module: sad_sched_acc, a single saturating lane accumulator (clear, enable, 12-bit add, ACC_W output), instantiated 5 times.
- FSM, row counter and compare scan stay in sad_sched.

Test Plan:
- Defaults; start; row_valid=1 constant; every row lanes h..i = 100,90,80,70,60 -> done at cycle 12, best_idx=4, best_sad=360.
- All lanes equal 50 every row -> best_idx=0 (tie to lowest), best_sad=300.
- row_valid deasserted 3 cycles in the middle of row 2 -> accumulators unchanged while stalled; done at cycle 15; results identical to the no-stall run.
- ACC_W=12, NUM_ROWS=6, all lanes 4095 -> all accumulators saturate at 4095; best_idx=0, best_sad=4095.
- rst pulsed during RUN at row 3, then a new start -> no done from the aborted block; new block result is correct with no residue; start during busy ignored.
- SAD_SCHED_ABORT_EN defined: abort at the first CMP cycle -> no done; busy=0 next cycle; best_* retain the previous block's values.

Source files
------------

// File: rtl/sad_sched_pkg.sv
// Shared constants and FSM state type for the block SAD scheduler.
package sad_sched_pkg;

    localparam int NUM_LANES = 5;
    localparam int LANE_W    = 12;

    localparam logic [2:0] LANE_H = 3'd0;
    localparam logic [2:0] LANE_Q = 3'd1;
    localparam logic [2:0] LANE_F = 3'd2;
    localparam logic [2:0] LANE_R = 3'd3;
    localparam logic [2:0] LANE_I = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_CMP,
        ST_DONE
    } state_e;

endpackage

// File: rtl/sad_sched_if.sv
// Control/row handshake bundle between ME control, the scheduler and the row SAD datapath.
// The abort input exists only when SAD_SCHED_ABORT_EN is defined.
interface sad_sched_if
    import sad_sched_pkg::*;
#(
    parameter int ACC_W = 16
);

    logic                          start;
    logic                          row_req;
    logic [5:0]                    row_idx;
    logic                          row_valid;
    logic [NUM_LANES*LANE_W-1:0]   sad_vector;
    logic                          busy;
    logic                          done;
    logic [2:0]                    best_idx;
    logic [ACC_W-1:0]              best_sad;
`ifdef SAD_SCHED_ABORT_EN
    logic                          abort;

    modport master (
        output start, row_valid, sad_vector, abort,
        input  row_req, row_idx, busy, done, best_idx, best_sad
    );

    modport slave (
        input  start, row_valid, sad_vector, abort,
        output row_req, row_idx, busy, done, best_idx, best_sad
    );
`else
    modport master (
        output start, row_valid, sad_vector,
        input  row_req, row_idx, busy, done, best_idx, best_sad
    );

    modport slave (
        input  start, row_valid, sad_vector,
        output row_req, row_idx, busy, done, best_idx, best_sad
    );
`endif

endinterface

// File: rtl/sad_sched_acc.sv
// One saturating lane accumulator: clear wins over enable, adds a zero-extended 12-bit SAD.
module sad_sched_acc
    import sad_sched_pkg::*;
#(
    parameter int ACC_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_i,
    input  logic              en_i,
    input  logic [LANE_W-1:0] add_i,
    output logic [ACC_W-1:0]  acc_o
);

    logic [ACC_W-1:0] acc_q, acc_d;
    logic [ACC_W:0]   sum;

    // One extra bit catches the carry that signals saturation.
    assign sum = {1'b0, acc_q} + {{(ACC_W + 1 - LANE_W){1'b0}}, add_i};

    always_comb begin
        acc_d = acc_q;
        if (clr_i) begin
            acc_d = '0;
        end else if (en_i) begin
            acc_d = sum[ACC_W] ? '1 : sum[ACC_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/sad_sched.sv
// Row-by-row SAD accumulation over one block, then a 5-cycle minimum scan over the lanes.
// Optional SAD_SCHED_ABORT_EN adds an abort input honoured in RUN and CMP.
module sad_sched
    import sad_sched_pkg::*;
#(
    parameter int NUM_ROWS = 6,
    parameter int ACC_W    = 16
) (
    input  logic         clk,
    input  logic         rst,
    sad_sched_if.slave   bus
);

    localparam logic [5:0] LAST_ROW = 6'(NUM_ROWS - 1);

    state_e           state_q, state_d;
    logic [5:0]       row_q, row_d;
    logic [2:0]       scan_q, scan_d;
    logic [2:0]       min_idx_q, min_idx_d;
    logic [ACC_W-1:0] min_sad_q, min_sad_d;
    logic [2:0]       best_idx_q, best_idx_d;
    logic [ACC_W-1:0] best_sad_q, best_sad_d;
    logic             acc_clr, acc_en, abort_req;
    logic [ACC_W-1:0] acc [NUM_LANES];
    logic [ACC_W-1:0] scan_sad;

`ifdef SAD_SCHED_ABORT_EN
    assign abort_req = bus.abort;
`else
    assign abort_req = 1'b0;
`endif

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        sad_sched_acc #(.ACC_W(ACC_W)) u_acc (
            .clk   (clk),
            .rst   (rst),
            .clr_i (acc_clr),
            .en_i  (acc_en),
            .add_i (bus.sad_vector[g*LANE_W +: LANE_W]),
            .acc_o (acc[g])
        );
    end

    assign scan_sad = acc[scan_q];

    always_comb begin
        state_d    = state_q;
        row_d      = row_q;
        scan_d     = scan_q;
        min_idx_d  = min_idx_q;
        min_sad_d  = min_sad_q;
        best_idx_d = best_idx_q;
        best_sad_d = best_sad_q;
        acc_clr    = 1'b0;
        acc_en     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    acc_clr = 1'b1;
                    row_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (abort_req) begin
                    acc_clr = 1'b1;
                    row_d   = '0;
                    state_d = ST_IDLE;
                end else if (bus.row_valid) begin
                    acc_en = 1'b1;
                    if (row_q == LAST_ROW) begin
                        row_d   = '0;
                        scan_d  = LANE_H;
                        state_d = ST_CMP;
                    end else begin
                        row_d = row_q + 6'd1;
                    end
                end
            end
            ST_CMP: begin
                if (abort_req) begin
                    acc_clr = 1'b1;
                    scan_d  = LANE_H;
                    state_d = ST_IDLE;
                end else begin
                    // Strict less-than keeps ties on the lowest lane index.
                    if (scan_q == LANE_H || scan_sad < min_sad_q) begin
                        min_sad_d = scan_sad;
                        min_idx_d = scan_q;
                    end
                    if (scan_q == LANE_I) begin
                        best_idx_d = min_idx_d;
                        best_sad_d = min_sad_d;
                        scan_d     = LANE_H;
                        state_d    = ST_DONE;
                    end else begin
                        scan_d = scan_q + 3'd1;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            row_q      <= '0;
            scan_q     <= '0;
            min_idx_q  <= '0;
            min_sad_q  <= '0;
            best_idx_q <= '0;
            best_sad_q <= '0;
        end else begin
            state_q    <= state_d;
            row_q      <= row_d;
            scan_q     <= scan_d;
            min_idx_q  <= min_idx_d;
            min_sad_q  <= min_sad_d;
            best_idx_q <= best_idx_d;
            best_sad_q <= best_sad_d;
        end
    end

    assign bus.row_req  = (state_q == ST_RUN);
    assign bus.row_idx  = row_q;
    assign bus.busy     = (state_q != ST_IDLE);
    assign bus.done     = (state_q == ST_DONE);
    assign bus.best_idx = best_idx_q;
    assign bus.best_sad = best_sad_q;

endmodule

// File: tb/tb_sad_sched.sv
// Directed bench for sad_sched: default instance plus an ACC_W=12 instance for saturation.
// Abort scenario is included when SAD_SCHED_ABORT_EN is defined.
module tb_sad_sched;

    logic clk;
    logic rst;
    int   checkCount;
    int   errorCount;

    sad_sched_if #(.ACC_W(16)) ifA ();
    sad_sched_if #(.ACC_W(12)) ifB ();

    sad_sched #(.NUM_ROWS(6), .ACC_W(16)) dutA (.clk(clk), .rst(rst), .bus(ifA.slave));
    sad_sched #(.NUM_ROWS(6), .ACC_W(12)) dutB (.clk(clk), .rst(rst), .bus(ifB.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Runs one block from a start pulse; returns done cycle, result, row_req count and best_* seen at cycle 3.
    task automatic applyStimulus(
        input  bit          sel,
        input  logic [59:0] vec,
        input  int          stallRow,
        input  int          stallLen,
        input  int          extraStartCycle,
        output int          doneCycle,
        output logic [2:0]  bi,
        output logic [15:0] bs,
        output int          reqCycles,
        output logic [2:0]  midBi,
        output logic [15:0] midBs
    );
        int   stalls;
        logic rq, dn;
        logic [5:0] ri;
        doneCycle = -1;
        reqCycles = 0;
        stalls    = 0;
        bi = '0; bs = '0; midBi = '0; midBs = '0;
        @(negedge clk);
        if (sel) begin ifB.start = 1'b1; ifB.sad_vector = vec; ifB.row_valid = 1'b1; end
        else     begin ifA.start = 1'b1; ifA.sad_vector = vec; ifA.row_valid = 1'b1; end
        @(negedge clk);
        for (int c = 1; c <= 100; c++) begin
            if (sel) ifB.start = (c == extraStartCycle);
            else     ifA.start = (c == extraStartCycle);
            rq = sel ? ifB.row_req : ifA.row_req;
            ri = sel ? ifB.row_idx : ifA.row_idx;
            dn = sel ? ifB.done    : ifA.done;
            if (c == 3) begin
                midBi = sel ? ifB.best_idx : ifA.best_idx;
                midBs = sel ? 16'(ifB.best_sad) : ifA.best_sad;
            end
            if (dn) begin
                doneCycle = c;
                bi = sel ? ifB.best_idx : ifA.best_idx;
                bs = sel ? 16'(ifB.best_sad) : ifA.best_sad;
                break;
            end
            if (rq) reqCycles++;
            if (rq && ri == 6'(stallRow) && stalls < stallLen) begin
                stalls++;
                if (sel) ifB.row_valid = 1'b0; else ifA.row_valid = 1'b0;
            end else begin
                if (sel) ifB.row_valid = 1'b1; else ifA.row_valid = 1'b1;
            end
            @(negedge clk);
        end
        ifA.start = 1'b0; ifB.start = 1'b0;
        ifA.row_valid = 1'b0; ifB.row_valid = 1'b0;
    endtask

    function automatic logic [59:0] packLanes(input int h, input int q, input int f, input int r, input int i);
        return {12'(i), 12'(r), 12'(f), 12'(q), 12'(h)};
    endfunction

    int          doneCycle, reqCycles, doneSeen;
    logic [2:0]  bi, midBi;
    logic [15:0] bs, midBs;

    initial begin
        checkCount = 0;
        errorCount = 0;
        rst = 1'b1;
        ifA.start = 1'b0; ifA.row_valid = 1'b0; ifA.sad_vector = '0;
        ifB.start = 1'b0; ifB.row_valid = 1'b0; ifB.sad_vector = '0;
`ifdef SAD_SCHED_ABORT_EN
        ifA.abort = 1'b0; ifB.abort = 1'b0;
`endif
        repeat (2) @(negedge clk);
        rst = 1'b0;
        checkOutput("rst_row_req",  32'(ifA.row_req),  0);
        checkOutput("rst_row_idx",  32'(ifA.row_idx),  0);
        checkOutput("rst_busy",     32'(ifA.busy),     0);
        checkOutput("rst_done",     32'(ifA.done),     0);
        checkOutput("rst_best_idx", 32'(ifA.best_idx), 0);
        checkOutput("rst_best_sad", 32'(ifA.best_sad), 0);

        // Descending lanes: i is cheapest, 6*60 = 360.
        applyStimulus(0, packLanes(100, 90, 80, 70, 60), -1, 0, -1, doneCycle, bi, bs, reqCycles, midBi, midBs);
        checkOutput("t1_done_cycle", 32'(doneCycle), 12);
        checkOutput("t1_req_cycles", 32'(reqCycles), 6);
        checkOutput("t1_best_idx",   32'(bi), 4);
        checkOutput("t1_best_sad",   32'(bs), 360);

        // All equal: tie resolves to lane h, back-to-back start.
        applyStimulus(0, packLanes(50, 50, 50, 50, 50), -1, 0, -1, doneCycle, bi, bs, reqCycles, midBi, midBs);
        checkOutput("t2_mid_best_idx", 32'(midBi), 4);
        checkOutput("t2_mid_best_sad", 32'(midBs), 360);
        checkOutput("t2_done_cycle",   32'(doneCycle), 12);
        checkOutput("t2_best_idx",     32'(bi), 0);
        checkOutput("t2_best_sad",     32'(bs), 300);

        // Three stall cycles on row 2.
        applyStimulus(0, packLanes(100, 90, 80, 70, 60), 2, 3, -1, doneCycle, bi, bs, reqCycles, midBi, midBs);
        checkOutput("t3_mid_best_sad", 32'(midBs), 300);
        checkOutput("t3_done_cycle",   32'(doneCycle), 15);
        checkOutput("t3_req_cycles",   32'(reqCycles), 9);
        checkOutput("t3_best_idx",     32'(bi), 4);
        checkOutput("t3_best_sad",     32'(bs), 360);

        // ACC_W=12 instance saturates every lane at 4095.
        applyStimulus(1, packLanes(4095, 4095, 4095, 4095, 4095), -1, 0, -1, doneCycle, bi, bs, reqCycles, midBi, midBs);
        checkOutput("t4_done_cycle", 32'(doneCycle), 12);
        checkOutput("t4_best_idx",   32'(bi), 0);
        checkOutput("t4_best_sad",   32'(bs), 4095);

        // Reset during RUN at row 3.
        @(negedge clk);
        ifA.start = 1'b1; ifA.sad_vector = packLanes(100, 90, 80, 70, 60); ifA.row_valid = 1'b1;
        @(negedge clk);
        ifA.start = 1'b0;
        for (int c = 0; c < 20 && !(ifA.row_req && ifA.row_idx == 6'd3); c++) @(negedge clk);
        checkOutput("t5_reached_row3", 32'(ifA.row_idx), 3);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        ifA.row_valid = 1'b0;
        checkOutput("t5_busy_after_rst",     32'(ifA.busy),     0);
        checkOutput("t5_row_req_after_rst",  32'(ifA.row_req),  0);
        checkOutput("t5_best_sad_after_rst", 32'(ifA.best_sad), 0);
        doneSeen = 0;
        for (int c = 0; c < 20; c++) begin
            if (ifA.done) doneSeen++;
            @(negedge clk);
        end
        checkOutput("t5_no_done", 32'(doneSeen), 0);
        // New block with a redundant start at cycle 3; f and i tie at 30, f wins.
        applyStimulus(0, packLanes(10, 20, 5, 30, 5), -1, 0, 3, doneCycle, bi, bs, reqCycles, midBi, midBs);
        checkOutput("t5_mid_best_sad", 32'(midBs), 0);
        checkOutput("t5_done_cycle",   32'(doneCycle), 12);
        checkOutput("t5_req_cycles",   32'(reqCycles), 6);
        checkOutput("t5_best_idx",     32'(bi), 2);
        checkOutput("t5_best_sad",     32'(bs), 30);

`ifdef SAD_SCHED_ABORT_EN
        // Abort on the first CMP cycle.
        @(negedge clk);
        ifA.start = 1'b1; ifA.sad_vector = packLanes(100, 90, 80, 70, 60); ifA.row_valid = 1'b1;
        @(negedge clk);
        ifA.start = 1'b0;
        for (int c = 0; c < 20 && !(ifA.busy && !ifA.row_req); c++) @(negedge clk);
        checkOutput("t6_in_cmp", 32'(ifA.busy && !ifA.row_req), 1);
        ifA.abort = 1'b1;
        @(negedge clk);
        ifA.abort = 1'b0;
        ifA.row_valid = 1'b0;
        checkOutput("t6_busy_after_abort", 32'(ifA.busy),     0);
        checkOutput("t6_done_after_abort", 32'(ifA.done),     0);
        checkOutput("t6_best_idx_kept",    32'(ifA.best_idx), 2);
        checkOutput("t6_best_sad_kept",    32'(ifA.best_sad), 30);
        doneSeen = 0;
        for (int c = 0; c < 10; c++) begin
            if (ifA.done) doneSeen++;
            @(negedge clk);
        end
        checkOutput("t6_no_done", 32'(doneSeen), 0);
        applyStimulus(0, packLanes(50, 50, 50, 50, 50), -1, 0, -1, doneCycle, bi, bs, reqCycles, midBi, midBs);
        checkOutput("t6_next_done_cycle", 32'(doneCycle), 12);
        checkOutput("t6_next_best_idx",   32'(bi), 0);
        checkOutput("t6_next_best_sad",   32'(bs), 300);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
